pn_token_tx: RTL and testbench

//  Host-side transmitter for the Polish-Notation evaluator token interface.
//  - Buffers a host-loaded expression of up to MAX_TOK tokens, validates its shape for the chosen mode,
//    and streams the tokens one per cycle on the evaluator's in_valid/mode/operator/in bus.
//  - Then collects the evaluator's out_valid/out results and signals completion.

---
 rtl/pn_token_tx.sv | 197 +++++++++++++++++++
 tb/tb_pn_token_tx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pn_token_tx.sv
// Host-side token transmitter for the Polish-notation evaluator: buffer, shape check, stream, collect.
// Optional response watchdog is enabled by defining PN_TX_TIMEOUT_EN.
module pn_token_tx #(
    parameter int unsigned MAX_TOK     = 12,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic        ld_op,
    input  logic [2:0]  ld_val,
    input  logic        start,
    input  logic [1:0]  start_mode,
    output logic        pn_in_valid,
    output logic [1:0]  pn_mode,
    output logic        pn_operator,
    output logic [2:0]  pn_in,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [1:0]  res_idx,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);
    localparam int unsigned IW = 4;
    localparam int unsigned NW = 3;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SEND, S_WAIT, S_DONE} state_t;

    if (MAX_TOK < 3 || MAX_TOK > 15 || TIMEOUT_CYC < 2) begin : g_cfg_check
        $error("pn_token_tx: unsupported MAX_TOK/TIMEOUT_CYC");
    end

    state_t        state, state_nx;
    logic [IW-1:0] count, idx, depth;
    logic          bad;
    logic [1:0]    mode;
    logic [NW-1:0] nres;
    logic          buf_op  [MAX_TOK];
    logic [2:0]    buf_val [MAX_TOK];

    logic          push_c, last_scan_c, chk_op_c, tok_bad_c, shape_bad_c, fail_c, timeout_c;
    logic [IW-1:0] chk_pos_c, depth_nx_c, count_nx, sel_c;
    logic [1:0]    phase_c;
    logic [NW-1:0] exp_c;

    logic          ld_ready_nx, busy_nx, done_nx, pn_in_valid_nx, pn_operator_nx, res_valid_nx;
    logic [1:0]    err_nx, pn_mode_nx;
    logic [2:0]    pn_in_nx;

    // Scan position walks backwards for full prefix so both full modes share the depth rule
    assign push_c      = (state == S_IDLE) && ld_valid && (count < IW'(MAX_TOK));
    assign last_scan_c = (idx == count - IW'(1));
    assign chk_pos_c   = (mode == 2'd2) ? (count - IW'(1) - idx) : idx;
    assign chk_op_c    = buf_op[chk_pos_c];
    assign phase_c     = 2'(idx % IW'(3));
    assign depth_nx_c  = chk_op_c ? (depth - IW'(1)) : (depth + IW'(1));
    assign exp_c       = mode[1] ? NW'(1) : NW'(count / IW'(3));
    assign fail_c      = bad | tok_bad_c | shape_bad_c;

    always_comb begin
        tok_bad_c   = 1'b0;
        shape_bad_c = 1'b0;
        case (mode)
            2'd0: begin
                tok_bad_c   = (chk_op_c != (phase_c == 2'd0));
                shape_bad_c = ((count % IW'(3)) != '0);
            end
            2'd1: begin
                tok_bad_c   = (chk_op_c != (phase_c == 2'd2));
                shape_bad_c = ((count % IW'(3)) != '0);
            end
            default: begin
                tok_bad_c   = chk_op_c && (depth < IW'(2));
                shape_bad_c = (depth_nx_c != IW'(1));
            end
        endcase
    end

`ifdef PN_TX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || state != S_WAIT || rsp_valid) wait_cnt <= '0;
        else                                        wait_cnt <= wait_cnt + TW'(1);
    end

    assign timeout_c = (state == S_WAIT) && !rsp_valid && (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_CHECK;
            S_CHECK: begin
                if (count == '0)      state_nx = S_DONE;
                else if (last_scan_c) state_nx = fail_c ? S_DONE : S_SEND;
            end
            S_SEND:  if (idx == count) state_nx = S_WAIT;
            S_WAIT:  if ((rsp_valid && (nres + NW'(1) == exp_c)) || timeout_c) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; token k is staged while idx points at k
    always_comb begin
        count_nx = count;
        if (push_c)          count_nx = count + IW'(1);
        if (state == S_DONE) count_nx = '0;
        ld_ready_nx    = (state_nx == S_IDLE) && (count_nx < IW'(MAX_TOK));
        busy_nx        = (state_nx != S_IDLE);
        done_nx        = (state_nx == S_DONE);
        err_nx         = err;
        if (state == S_IDLE && start) err_nx = 2'd0;
        if (state_nx == S_DONE)
            err_nx = (state == S_CHECK) ? 2'd1 : (timeout_c ? 2'd2 : 2'd0);
        pn_in_valid_nx = (state == S_CHECK && state_nx == S_SEND) || (state == S_SEND && idx != count);
        pn_mode_nx     = (state == S_CHECK && state_nx == S_SEND) ? mode : 2'd0;
        sel_c          = (pn_in_valid_nx && state == S_SEND) ? idx : '0;
        pn_operator_nx = pn_in_valid_nx ? buf_op[sel_c] : 1'b0;
        pn_in_nx       = pn_in_valid_nx ? buf_val[sel_c] : 3'd0;
        res_valid_nx   = (state == S_WAIT) && rsp_valid;
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            buf_op[count]  <= ld_op;
            buf_val[count] <= ld_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= '0;
            idx         <= '0;
            depth       <= '0;
            bad         <= 1'b0;
            mode        <= 2'd0;
            nres        <= '0;
            ld_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 2'd0;
            pn_in_valid <= 1'b0;
            pn_mode     <= 2'd0;
            pn_operator <= 1'b0;
            pn_in       <= 3'd0;
            res_valid   <= 1'b0;
            res_data    <= 32'd0;
            res_idx     <= 2'd0;
        end else begin
            count       <= count_nx;
            ld_ready    <= ld_ready_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            err         <= err_nx;
            pn_in_valid <= pn_in_valid_nx;
            pn_mode     <= pn_mode_nx;
            pn_operator <= pn_operator_nx;
            pn_in       <= pn_in_nx;
            res_valid   <= res_valid_nx;
            if (res_valid_nx) begin
                res_data <= rsp_data;
                res_idx  <= nres[1:0];
            end
            case (state)
                S_IDLE: if (start) begin
                    mode  <= start_mode;
                    idx   <= '0;
                    depth <= '0;
                    bad   <= 1'b0;
                    nres  <= '0;
                end
                S_CHECK: begin
                    idx   <= (state_nx == S_SEND) ? IW'(1) : idx + IW'(1);
                    depth <= depth_nx_c;
                    bad   <= bad | tok_bad_c;
                end
                S_SEND:  idx <= idx + IW'(1);
                S_WAIT:  if (rsp_valid) nres <= nres + NW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pn_token_tx.sv
// Self-checking bench for pn_token_tx: directed vector table, random expressions against a
// stack-based reference model, plus reset-abort and no-response sequences.
module tb_pn_token_tx;
    localparam int MAX = 12;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0, ld_ready, ld_op = 1'b0;
    logic [2:0]  ld_val = 3'd0;
    logic        start = 1'b0;
    logic [1:0]  start_mode = 2'd0;
    logic        pn_in_valid, pn_operator;
    logic [1:0]  pn_mode;
    logic [2:0]  pn_in;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'd0;
    logic        res_valid;
    logic [31:0] res_data;
    logic [1:0]  res_idx;
    logic        busy, done;
    logic [1:0]  err;

    always #5 clk = ~clk;

    pn_token_tx #(.MAX_TOK(MAX), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_op(ld_op),
        .ld_val(ld_val), .start(start), .start_mode(start_mode), .pn_in_valid(pn_in_valid),
        .pn_mode(pn_mode), .pn_operator(pn_operator), .pn_in(pn_in), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .busy(busy), .done(done), .err(err)
    );

    // Token code: 0..7 operand value, 8..11 operator (code-8)
    typedef struct {
        int mode;
        int n;
        int tok[16];
        bit merge;
        int exp_err;
        int exp_sent;
        int exp_res;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errs = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic void add_vec(input int mode, input bit merge, input int e_err,
                                    input int e_sent, input int e_res, input int q[$]);
        vec_t v;
        for (int i = 0; i < 16; i++) v.tok[i] = 0;
        v.mode = mode; v.merge = merge; v.n = q.size();
        v.exp_err = e_err; v.exp_sent = e_sent; v.exp_res = e_res;
        foreach (q[i]) v.tok[i] = q[i];
        tbl.push_back(v);
    endfunction

    // Reference: groups-of-3 pattern, or evaluate with an explicit operand stack
    function automatic bit model_ok(input int mode, input int n, input int tok[16]);
        int cnt;
        int seq[$];
        int stk[$];
        int a;
        cnt = (n > MAX) ? MAX : n;
        if (cnt == 0) return 1'b0;
        if (mode < 2) begin
            if (cnt % 3 != 0) return 1'b0;
            for (int i = 0; i < cnt; i++)
                if ((tok[i] >= 8) != ((i % 3) == ((mode == 0) ? 0 : 2))) return 1'b0;
            return 1'b1;
        end
        for (int i = 0; i < cnt; i++) seq.push_back((mode == 2) ? tok[cnt - 1 - i] : tok[i]);
        foreach (seq[k]) begin
            if (seq[k] >= 8) begin
                if (stk.size() < 2) return 1'b0;
                a = stk.pop_back();
                a = a + stk.pop_back();
                stk.push_back(a);
            end else begin
                stk.push_back(seq[k]);
            end
        end
        return stk.size() == 1;
    endfunction

    function automatic vec_t gen_rand();
        vec_t v;
        int q[$];
        int h, opnds, ops, cnt;
        for (int i = 0; i < 16; i++) v.tok[i] = 0;
        v.mode = $urandom_range(0, 3);
        v.merge = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
            if (v.mode < 2) begin
                for (int g = $urandom_range(1, 4); g > 0; g--)
                    for (int p = 0; p < 3; p++)
                        q.push_back((p == ((v.mode == 0) ? 0 : 2)) ? 8 + $urandom_range(0, 3)
                                                                   : $urandom_range(0, 7));
            end else begin
                opnds = $urandom_range(1, 6); ops = opnds - 1; h = 0;
                while (opnds > 0 || ops > 0) begin
                    if (h >= 2 && ops > 0 && (opnds == 0 || $urandom_range(0, 1) == 1)) begin
                        q.push_back(8 + $urandom_range(0, 3)); h--; ops--;
                    end else begin
                        q.push_back($urandom_range(0, 7)); h++; opnds--;
                    end
                end
                if (v.mode == 2) q.reverse();
            end
        end else begin
            for (int i = $urandom_range(0, 13); i > 0; i--)
                q.push_back(($urandom_range(0, 1) == 1) ? 8 + $urandom_range(0, 3) : $urandom_range(0, 7));
        end
        v.n = q.size();
        foreach (q[i]) v.tok[i] = q[i];
        cnt = (v.n > MAX) ? MAX : v.n;
        if (model_ok(v.mode, v.n, v.tok)) begin
            v.exp_err = 0; v.exp_sent = cnt; v.exp_res = (v.mode < 2) ? cnt / 3 : 1;
        end else begin
            v.exp_err = 1; v.exp_sent = 0; v.exp_res = 0;
        end
        return v;
    endfunction

    task automatic push_tok(input int t);
        @(negedge clk);
        ld_valid = 1'b1; ld_op = (t >= 8); ld_val = 3'(t % 8);
    endtask

    task automatic start_txn(input int mode);
        @(negedge clk);
        ld_valid = 1'b0; start = 1'b1; start_mode = 2'(mode);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int  cnt, sent, dones, err_seen, rsp_left, post, d;
        bit  mode_ok, tok_ok, gap, dropped, data_ok, idx_ok;
        int  exp_q[$];
        int  got_q[$];
        cnt = (v.n > MAX) ? MAX : v.n;
        sent = 0; dones = 0; err_seen = -1; rsp_left = v.exp_res; post = -1;
        mode_ok = 1; tok_ok = 1; gap = 0; dropped = 0; data_ok = 1; idx_ok = 1;
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            chk({tag, " ld_ready"}, int'(ld_ready), (i < MAX) ? 1 : 0);
            ld_valid = 1'b1; ld_op = (v.tok[i] >= 8); ld_val = 3'(v.tok[i] % 8);
            if (v.merge && i == v.n - 1) begin start = 1'b1; start_mode = 2'(v.mode); end
        end
        @(negedge clk);
        ld_valid = 1'b0;
        if (!(v.merge && v.n > 0)) begin
            start = 1'b1; start_mode = 2'(v.mode);
            @(negedge clk);
        end
        start = 1'b0;
        for (int c = 0; c < 400 && post != 0; c++) begin
            @(negedge clk);
            if (post > 0) post--;
            if (pn_in_valid) begin
                if (dropped) gap = 1;
                if (pn_mode != ((sent == 0) ? 2'(v.mode) : 2'd0)) mode_ok = 0;
                if (sent >= cnt || pn_operator != (v.tok[sent] >= 8) || pn_in != 3'(v.tok[sent] % 8))
                    tok_ok = 0;
                sent++;
            end else begin
                if (sent > 0) dropped = 1;
                if (pn_mode != 2'd0) mode_ok = 0;
            end
            if (res_valid) begin
                got_q.push_back(int'(res_data));
                if (int'(res_idx) != got_q.size() - 1) idx_ok = 0;
            end
            if (done) begin
                dones++; err_seen = int'(err);
                if (post < 0) post = 1;
            end
            rsp_valid = 1'b0;
            if (pn_in_valid) begin
                rsp_valid = ($urandom_range(0, 3) == 0);
                rsp_data = $urandom;
            end else if (dropped && rsp_left > 0 && $urandom_range(0, 2) != 0) begin
                d = int'($urandom);
                rsp_valid = 1'b1; rsp_data = 32'(d); exp_q.push_back(d); rsp_left--;
            end
        end
        rsp_valid = 1'b0;
        if (got_q.size() == exp_q.size())
            foreach (got_q[i]) if (got_q[i] != exp_q[i]) data_ok = 0;
        chk({tag, " sent"}, sent, v.exp_sent);
        chk({tag, " err"}, err_seen, v.exp_err);
        chk({tag, " done_count"}, dones, 1);
        chk({tag, " tokens"}, int'(tok_ok), 1);
        chk({tag, " pn_mode"}, int'(mode_ok), 1);
        chk({tag, " gap"}, int'(gap), 0);
        chk({tag, " n_results"}, got_q.size(), v.exp_res);
        chk({tag, " res_data"}, int'(data_ok), 1);
        chk({tag, " res_idx"}, int'(idx_ok), 1);
        chk({tag, " idle_busy"}, int'(busy), 0);
        chk({tag, " idle_ld_ready"}, int'(ld_ready), 1);
        chk({tag, " err_held"}, int'(err), v.exp_err);
    endtask

    task automatic no_rsp_test();
        int  wait_cyc, dn;
        bit  seen, dropped;
        wait_cyc = 0; dn = 0; seen = 0; dropped = 0;
        push_tok(3); push_tok(4); push_tok(8);
        start_txn(3);
        for (int c = 0; c < 300 && dn == 0; c++) begin
            @(negedge clk);
            if (pn_in_valid) seen = 1;
            else if (seen) dropped = 1;
            if (dropped) wait_cyc++;
            if (done) dn = 1;
        end
        chk("norsp sent", int'(seen), 1);
`ifdef PN_TX_TIMEOUT_EN
        chk("timeout done", dn, 1);
        chk("timeout cycle", wait_cyc, TMO + 1);
        chk("timeout err", int'(err), 2);
`else
        chk("hold no_done", dn, 0);
        chk("hold busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
    endtask

    initial begin
        int  tq[$];
        bit  seen;
        vec_t rv;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst ld_ready", int'(ld_ready), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst err", int'(err), 0);
        chk("rst pn_in_valid", int'(pn_in_valid), 0);
        chk("rst pn_fields", int'({pn_mode, pn_operator, pn_in}), 0);
        chk("rst res_valid", int'(res_valid), 0);
        chk("rst res_fields", int'(res_data) | int'(res_idx), 0);

        tq = '{3, 4, 8};              add_vec(3, 0, 0, 3, 1, tq);
        tq = '{10, 3, 5, 8, 1, 1};    add_vec(0, 0, 0, 6, 2, tq);
        tq = '{9, 10, 2, 3, 4};       add_vec(2, 0, 0, 5, 1, tq);
        tq = '{3, 8};                 add_vec(3, 0, 1, 0, 0, tq);
        tq.delete();                  add_vec(0, 0, 1, 0, 0, tq);
        tq.delete();
        for (int g = 0; g < 4; g++) begin tq.push_back(1); tq.push_back(2); tq.push_back(8); end
        tq.push_back(5);              add_vec(1, 0, 0, 12, 4, tq);
        tq = '{1, 2, 9};              add_vec(1, 1, 0, 3, 1, tq);
        tq = '{8, 1, 2, 3};           add_vec(0, 0, 1, 0, 0, tq);
        tq = '{1, 2, 8};              add_vec(2, 0, 1, 0, 0, tq);
        tq = '{1, 2};                 add_vec(3, 0, 1, 0, 0, tq);
        tq.delete();
        for (int g = 0; g < 4; g++) begin tq.push_back(8); tq.push_back(1); tq.push_back(2); end
        tq.push_back(9);              add_vec(0, 1, 0, 12, 4, tq);

        foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int r = 0; r < 40; r++) begin
            rv = gen_rand();
            run_txn(rv, $sformatf("rnd%0d", r));
        end

        // Abort in the middle of streaming
        foreach (tbl[1].tok[i]) if (i < tbl[1].n) push_tok(tbl[1].tok[i]);
        start_txn(0);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (pn_in_valid) seen = 1;
        end
        chk("abort sending", int'(seen), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort pn_in_valid", int'(pn_in_valid), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort ld_ready", int'(ld_ready), 1);
        chk("abort done", int'(done), 0);
        rst_n = 1'b1;
        run_txn(tbl[0], "after_abort");

        no_rsp_test();
        run_txn(tbl[2], "final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
